// File: rtl/fp_div_pkg.sv
// Shared field widths, constants and FSM encoding for the sequential FP divider.
package fp_div_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int QBITS    = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Assemble a single-precision word from its three fields.
  function automatic logic [31:0] pack_fp(input logic [SIGN_W-1:0] s,
                                          input logic [EXP_W-1:0]  e,
                                          input logic [MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_divider_seq_if.sv
// Handshake and operand/result bundle between the controller and the divider.
interface fp_divider_seq_if;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        dz_o;

  modport master (output start_i, a_i, b_i, input busy_o, done_o, result_o, dz_o);
  modport slave  (input start_i, a_i, b_i, output busy_o, done_o, result_o, dz_o);
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit mantissa plus final range check and packing.
module fp_round_rne
  import fp_div_pkg::*;
(
  input  logic              [23:0] mant_i,
  input  logic                     guard_i,
  input  logic                     sticky_i,
  input  logic signed       [9:0]  exp_i,
  input  logic                     sign_i,
  output logic              [31:0] result_o
);

  logic              inc_s;
  logic [24:0]       sum_s;
  logic [23:0]       mant_s;
  logic signed [9:0] exp_s;

  // Increment on guard when sticky or odd, renormalise a carry-out, then clamp range.
  always_comb begin
    inc_s = guard_i & (sticky_i | mant_i[0]);
    sum_s = {1'b0, mant_i} + {24'd0, inc_s};
    if (sum_s[24]) begin
      mant_s = 24'h80_0000;
      exp_s  = exp_i + 10'sd1;
    end else begin
      mant_s = sum_s[23:0];
      exp_s  = exp_i;
    end
    if (exp_s >= 10'sd255) begin
      result_o = POS_INF | {sign_i, 31'd0};
    end else if (exp_s <= 10'sd0) begin
      result_o = ZERO | {sign_i, 31'd0};
    end else begin
      result_o = pack_fp(sign_i, exp_s[7:0], mant_s[22:0]);
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Multi-cycle IEEE-754 single-precision divider: restoring mantissa division, RNE rounding.
module fp_divider_seq
  import fp_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fp_divider_seq_if.slave    bus
);

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [QBITS-1:0]    rem_q, rem_d;
  logic [23:0]         mb_q, mb_d;
  logic [QBITS-1:0]    quot_q, quot_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [23:0]         mant_q, mant_d;
  logic                guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]         result_q, result_d;
  logic                dz_q, dz_d, busy_q, busy_d, done_q, done_d;

  logic                sa_s, sb_s;
  logic [EXP_W-1:0]    ea_s, eb_s;
  logic [MANT_W-1:0]   fa_s, fb_s;
  logic                a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [QBITS:0]      diff_s;
  logic [QBITS-1:0]    rem_next_s;
  logic [31:0]         rnd_res_s;

  fp_round_rne u_round (
    .mant_i   (mant_q),
    .guard_i  (guard_q),
    .sticky_i (sticky_q),
    .exp_i    (exp_q),
    .sign_i   (sign_q),
    .result_o (rnd_res_s)
  );

  // Operand classification; denormals are treated as zero.
  always_comb begin
    sa_s     = a_q[31];
    sb_s     = b_q[31];
    ea_s     = a_q[30:23];
    eb_s     = b_q[30:23];
    fa_s     = a_q[22:0];
    fb_s     = b_q[22:0];
    a_zero_s = (ea_s == 8'h00);
    b_zero_s = (eb_s == 8'h00);
    a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
    b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
    a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
    b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
    diff_s     = {1'b0, rem_q} - {3'b000, mb_q};
    rem_next_s = diff_s[QBITS] ? rem_q : diff_s[QBITS-1:0];
  end

  // Next-state and datapath update for each FSM phase; outputs derived from next state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        sign_d = sa_s ^ sb_s;
        if (a_nan_s || b_nan_s) begin
          result_d = QNAN;
          state_d  = S_DONE;
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
          result_d = QNAN;
          state_d  = S_DONE;
        end else if (b_zero_s) begin
          result_d = POS_INF | {sa_s ^ sb_s, 31'd0};
          dz_d     = 1'b1;
          state_d  = S_DONE;
        end else if (a_inf_s) begin
          result_d = POS_INF | {sa_s ^ sb_s, 31'd0};
          state_d  = S_DONE;
        end else if (a_zero_s || b_inf_s) begin
          result_d = ZERO | {sa_s ^ sb_s, 31'd0};
          state_d  = S_DONE;
        end else begin
          exp_d   = {2'b00, ea_s} - {2'b00, eb_s} + 10'(EXP_BIAS);
          rem_d   = {2'b00, 1'b1, fa_s};
          mb_d    = {1'b1, fb_s};
          quot_d  = {QBITS{1'b0}};
          cnt_d   = 5'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        quot_d = {quot_q[QBITS-2:0], ~diff_s[QBITS]};
        rem_d  = rem_next_s << 1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) begin
          state_d = S_NORM;
        end else begin
          state_d = S_DIV;
        end
      end
      S_NORM: begin
        if (quot_q[QBITS-1]) begin
          mant_d   = quot_q[25:2];
          guard_d  = quot_q[1];
          sticky_d = quot_q[0] | (rem_q != {QBITS{1'b0}});
        end else begin
          mant_d   = quot_q[24:1];
          guard_d  = quot_q[0];
          sticky_d = (rem_q != {QBITS{1'b0}});
          exp_d    = exp_q - 10'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = rnd_res_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      rem_q    <= {QBITS{1'b0}};
      mb_q     <= 24'd0;
      quot_q   <= {QBITS{1'b0}};
      cnt_q    <= 5'd0;
      mant_q   <= 24'd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= ZERO;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.dz_o     = dz_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed self-checking bench for fp_divider_seq.
module tb_fp_divider_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_divider_seq_if dif();

  fp_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; cyc counts cycles after the start edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic dz,
                        output int cyc, output logic busy_all);
    @(negedge clk);
    dif.a_i = a;
    dif.b_i = b;
    dif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    cyc = 1;
    busy_all = dif.busy_o;
    while (!dif.done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
      busy_all = busy_all & dif.busy_o;
    end
    res = dif.result_o;
    dz  = dif.dz_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", dif.busy_o); end
    checks++; if (dif.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dif.done_o); end
    checks++; if (dif.result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", dif.result_o); end
    checks++; if (dif.dz_o !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", dif.dz_o); end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [31:0] res; logic dz; int cyc; logic ball;
    run_op(32'h41100000, 32'h40400000, res, dz, cyc, ball);
    checks++; if (res !== 32'h40400000) begin errors++; $display("FAIL div9_3 got %h want 40400000", res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div9_3_dz got %b want 0", dz); end
    checks++; if (cyc !== 30) begin errors++; $display("FAIL div9_3_latency got %0d want 30", cyc); end
    checks++; if (ball !== 1'b1) begin errors++; $display("FAIL div9_3_busy got %b want 1", ball); end
    @(negedge clk);
    checks++; if (dif.done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", dif.done_o); end
    checks++; if (dif.result_o !== 32'h40400000) begin errors++; $display("FAIL result_hold got %h want 40400000", dif.result_o); end
  endtask

  task automatic test_rounding();
    logic [31:0] res; logic dz; int cyc; logic ball;
    run_op(32'h3F800000, 32'h40400000, res, dz, cyc, ball);
    checks++; if (res !== 32'h3EAAAAAB) begin errors++; $display("FAIL div1_3 got %h want 3eaaaaab", res); end
    run_op(32'h3C23D70A, 32'h40000000, res, dz, cyc, ball);
    checks++; if (res !== 32'h3BA3D70A) begin errors++; $display("FAIL div001_2 got %h want 3ba3d70a", res); end
    checks++; if (cyc !== 30) begin errors++; $display("FAIL div001_2_latency got %0d want 30", cyc); end
  endtask

  task automatic test_specials();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    logic        vz [3];
    logic [31:0] res; logic dz; int cyc; logic ball;
    va[0] = 32'h40000000; vb[0] = 32'h00000000; vr[0] = 32'h7F800000; vz[0] = 1'b1;
    va[1] = 32'h00000000; vb[1] = 32'h00000000; vr[1] = 32'h7FC00000; vz[1] = 1'b0;
    va[2] = 32'hBF800000; vb[2] = 32'h7F800000; vr[2] = 32'h80000000; vz[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], res, dz, cyc, ball);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL special%0d_result got %h want %h", i, res, vr[i]); end
      checks++; if (dz !== vz[i]) begin errors++; $display("FAIL special%0d_dz got %b want %b", i, dz, vz[i]); end
      checks++; if (cyc !== 2) begin errors++; $display("FAIL special%0d_latency got %0d want 2", i, cyc); end
    end
  endtask

  task automatic test_range();
    logic [31:0] res; logic dz; int cyc; logic ball;
    run_op(32'h7F000000, 32'h3E800000, res, dz, cyc, ball);
    checks++; if (res !== 32'h7F800000) begin errors++; $display("FAIL overflow got %h want 7f800000", res); end
    run_op(32'h00800000, 32'h40000000, res, dz, cyc, ball);
    checks++; if (res !== 32'h00000000) begin errors++; $display("FAIL underflow got %h want 00000000", res); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    dif.a_i = 32'h41100000; dif.b_i = 32'h40400000; dif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    cyc = 1;
    while (!dif.done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        dif.a_i = 32'h3F800000; dif.b_i = 32'h40000000; dif.start_i = 1'b1;
      end else begin
        dif.start_i = 1'b0;
      end
    end
    checks++; if (cyc !== 30) begin errors++; $display("FAIL ignore_latency got %0d want 30", cyc); end
    checks++; if (dif.result_o !== 32'h40400000) begin errors++; $display("FAIL ignore_result got %h want 40400000", dif.result_o); end
    dif.a_i = 32'h3F800000; dif.b_i = 32'h40400000; dif.start_i = 1'b1;
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL start_in_done got busy %b want 0", dif.busy_o); end
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b1) begin errors++; $display("FAIL start_after_done got busy %b want 1", dif.busy_o); end
    dif.start_i = 1'b0;
    cyc = 1;
    while (!dif.done_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 30) begin errors++; $display("FAIL b2b_latency got %0d want 30", cyc); end
    checks++; if (dif.result_o !== 32'h3EAAAAAB) begin errors++; $display("FAIL b2b_result got %h want 3eaaaaab", dif.result_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic dz; int cyc; logic ball; int pulses;
    @(negedge clk);
    dif.a_i = 32'h41100000; dif.b_i = 32'h40400000; dif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dif.busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", dif.busy_o); end
    checks++; if (dif.result_o !== 32'h0) begin errors++; $display("FAIL midrst_result got %h want 00000000", dif.result_o); end
    checks++; if (dif.done_o !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", dif.done_o); end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.done_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", pulses); end
    run_op(32'h3C23D70A, 32'h40000000, res, dz, cyc, ball);
    checks++; if (res !== 32'h3BA3D70A) begin errors++; $display("FAIL post_rst_result got %h want 3ba3d70a", res); end
    checks++; if (cyc !== 30) begin errors++; $display("FAIL post_rst_latency got %0d want 30", cyc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.start_i = 1'b0;
    dif.a_i = 32'h0;
    dif.b_i = 32'h0;
    test_reset();
    test_normal();
    test_rounding();
    test_specials();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
